mux_16to1_beh: RTL and testbench
================================

Name: mux_16to1_beh

Overview:
- Behavioural 16:1 single-bit multiplexer: selects one bit of a 16-bit input vector by a 4-bit index.
- Combinational output `out` serves glue logic that needs a zero-latency result.
- Registered copy `out_q`, with a valid flag, serves timing-closed downstream stages.
- Leaf block in the datapath glue library; one clock domain.

Parameters:
- N_IN, 16, number of selectable input bits (legal range 2..16).
- SEL_W, 4, select width; fixed to 4, supports N_IN <= 16.
- RST_VAL, 1'b0, reset value of `out_q`.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous, active-low reset.
- in  input  N_IN  data bits; in[k] is selected when sel == k.
- sel  input  SEL_W  select index, unsigned.
- in_valid  input  1  qualifies in/sel for the registered path.
- out  output  1  combinational: in[sel].
- out_q  output  1  registered selected bit.
- out_valid  output  1  registered in_valid.

Behaviour:
- Reset is synchronous and active-low: sampled only on the rising edge of clk; no asynchronous path.
- Combinational path:
  - out = in[sel] whenever sel < N_IN.
  - out = 0 when sel >= N_IN (only possible when N_IN < 16).
  - Zero latency; changes on any change of in or sel, with no clock dependency.
  - Never X for known inputs; implement with a full case or an index plus range check.
  - out is unaffected by rst_n.
- Registered path, on each rising clk edge:
  - rst_n == 0: out_q <= RST_VAL, out_valid <= 0. Reset wins over any simultaneous in_valid.
  - rst_n == 1 and in_valid == 1: out_q <= out (the current combinational value); out_valid <= 1.
  - rst_n == 1 and in_valid == 0: out_q holds its value; out_valid <= 0.
- Latency: out_q and out_valid follow in/sel/in_valid by exactly 1 cycle.
- Back-to-back in_valid cycles each produce one out_valid pulse; no backpressure, no stall.
- Reset asserted mid-stream: the pending result is discarded; out_valid reads 0 on the cycle after the reset edge.
- sel out of range with in_valid == 1: out_q captures 0 and out_valid still asserts.
- No internal state beyond out_q and out_valid.

Decomposition:
- Shared package `mux_pkg`:
  - localparam MUX_SEL_W = 4.
  - Function `mux_sel_bit(vec, idx, n)`: returns vec[idx], or 0 when idx >= n.
- No sub-module. The single select function is reused by both the combinational and the registered paths, so they cannot diverge.

Test Plan:
- Reset: hold rst_n = 0 for 2 clk edges with in_valid = 1 -> out_q = 0 and out_valid = 0 at each edge. Combinational out still tracks in[sel] during reset.
- Combinational sweep: in = 16'h3F0A; sel = 0, 1, 6, 12 in turn -> out = 0, 1, 0, 1 respectively, with no clock edge required.
- Exhaustive: for each sel in 0..15, drive one-hot in = 1 << sel -> out = 1. Then drive in = ~(1 << sel) -> out = 0.
- Registered latency: in = 16'h3F0A, sel = 1, in_valid = 1 for one edge, then in_valid = 0 -> out_q = 1 and out_valid = 1 one cycle later. Next cycle out_valid = 0 and out_q holds 1.
- Mid-stream reset: in_valid = 1 streaming sel = 12, 13 (in = 16'h3F0A); assert rst_n = 0 coincident with the second edge -> out_q = 0 and out_valid = 0 after that edge.
- Out-of-range (N_IN = 10 build): sel = 12, in = all ones, in_valid = 1 -> out = 0, and out_q = 0 with out_valid = 1 after one edge.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and the single select function used by the
// 16:1 mux leaf. Both the combinational and registered paths call
// mux_sel_bit, so they cannot disagree on the selected bit.
package mux_pkg;

   localparam int MUX_SEL_W = 4;
   localparam int MUX_MAX_N = 1 << MUX_SEL_W;

   // Returns vec[idx], or 0 when idx addresses a bit beyond the populated
   // width n. This keeps the result known when the index is out of range.
   function automatic logic mux_sel_bit(input logic [MUX_MAX_N-1:0] vec,
                                        input logic [MUX_SEL_W-1:0] idx,
                                        input int unsigned          n);
      logic [31:0] idx_ext;
      idx_ext = {{(32-MUX_SEL_W){1'b0}}, idx};
      if (idx_ext >= n) return 1'b0;
      return vec[idx];
   endfunction

endpackage

// File: rtl/mux_16to1_beh.sv
// mux_16to1_beh: behavioural N_IN:1 single-bit mux (N_IN <= 16).
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   in        - data bits, in[k] selected when sel == k
//   sel       - unsigned select index
//   in_valid  - qualifies in/sel for the registered path
//   out       - combinational in[sel] (0 when sel >= N_IN)
//   out_q     - registered selected bit, captured when in_valid
//   out_valid - in_valid delayed by one cycle
module mux_16to1_beh
   import mux_pkg::*;
#(
   parameter int   N_IN    = 16,
   parameter int   SEL_W   = MUX_SEL_W,
   parameter logic RST_VAL = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_IN-1:0] in,
   input  logic [SEL_W-1:0] sel,
   input  logic            in_valid,
   output logic            out,
   output logic            out_q,
   output logic            out_valid
);

   // Zero-extend to the full 16-bit vector the select function expects;
   // bits at or above N_IN are masked by the range check anyway.
   logic [MUX_MAX_N-1:0] in_ext;

   always_comb begin
      in_ext           = '0;
      in_ext[N_IN-1:0] = in;
   end

   always_comb out = mux_sel_bit(in_ext, sel, N_IN);

   // out_q holds when in_valid is low; out_valid is a one-cycle echo.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q     <= RST_VAL;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) out_q <= out;
      end
   end

endmodule

// File: tb/tb_mux_16to1_beh.sv
// tb_mux_16to1_beh: directed self-checking bench for mux_16to1_beh.
// Instantiates a full 16-input build and a 10-input build for the
// out-of-range select case.
module tb_mux_16to1_beh;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in;
   logic [3:0]  sel;
   logic        in_valid;
   logic        out, out_q, out_valid;

   logic [9:0]  in10;
   logic [3:0]  sel10;
   logic        in_valid10;
   logic        out10, out_q10, out_valid10;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mux_16to1_beh #(.N_IN(16)) dut (
      .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .in_valid(in_valid),
      .out(out), .out_q(out_q), .out_valid(out_valid)
   );

   mux_16to1_beh #(.N_IN(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .in(in10), .sel(sel10), .in_valid(in_valid10),
      .out(out10), .out_q(out_q10), .out_valid(out_valid10)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  sv [4];
      logic        ev [4];
      logic [15:0] oh;
      sv = '{4'd0, 4'd1, 4'd6, 4'd12};
      ev = '{1'b0, 1'b1, 1'b0, 1'b1};

      // reset held for two edges with in_valid high
      rst_n = 1'b0; in = 16'h3F0A; sel = 4'd1; in_valid = 1'b1;
      in10 = '1; sel10 = 4'd9; in_valid10 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_out_q", out_q, 1'b0);
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_comb_out", out, 1'b1);
      end

      // combinational sweep, no clock edges
      rst_n = 1'b1; in_valid = 1'b0; in_valid10 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         sel = sv[i];
         #1;
         chk("comb_sweep", out, ev[i]);
      end

      // exhaustive one-hot / one-cold
      for (int s = 0; s < 16; s++) begin
         sel = 4'(s);
         oh  = 16'd1 << s;
         in  = oh;
         #1 chk("onehot", out, 1'b1);
         in  = ~oh;
         #1 chk("onecold", out, 1'b0);
      end

      // registered latency and hold
      in = 16'h3F0A; sel = 4'd1; in_valid = 1'b1;
      tick();
      chk("lat_out_q", out_q, 1'b1);
      chk("lat_out_valid", out_valid, 1'b1);
      in_valid = 1'b0; sel = 4'd0;
      tick();
      chk("hold_out_valid", out_valid, 1'b0);
      chk("hold_out_q", out_q, 1'b1);

      // capture a zero, then stream sel 12, 13 with reset on the second edge
      in_valid = 1'b1; sel = 4'd0;
      tick();
      chk("cap0_out_q", out_q, 1'b0);
      sel = 4'd12;
      tick();
      chk("stream12_out_q", out_q, 1'b1);
      chk("stream12_out_valid", out_valid, 1'b1);
      sel = 4'd13; rst_n = 1'b0;
      tick();
      chk("midrst_out_q", out_q, 1'b0);
      chk("midrst_out_valid", out_valid, 1'b0);
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
      chk("post_rst_out_valid", out_valid, 1'b0);

      // 10-input build: in-range capture, then out-of-range select
      in10 = '1; sel10 = 4'd9; in_valid10 = 1'b1;
      #1 chk("n10_sel9_out", out10, 1'b1);
      tick();
      chk("n10_sel9_out_q", out_q10, 1'b1);
      sel10 = 4'd12;
      #1 chk("n10_oor_out", out10, 1'b0);
      tick();
      chk("n10_oor_out_q", out_q10, 1'b0);
      chk("n10_oor_out_valid", out_valid10, 1'b1);
      sel10 = 4'd15; in_valid10 = 1'b0;
      #1 chk("n10_sel15_out", out10, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
